// File: rtl/img_pkg.sv
// Shared definitions for the image row packer and the row buffer it feeds.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package img_pkg;

  // Default geometry: 20 words of 32 bits per 640-bit row, 480 rows per frame.
  localparam int DEF_WORD_W   = 32;
  localparam int DEF_ROW_W    = 640;
  localparam int DEF_NUM_ROWS = 480;

  // Row-buffer address width; covers up to 512 rows.
  localparam int ROW_ADDR_W   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/img_row_packer.sv
// Packs WORD_W-bit pixel words into ROW_W-bit rows and writes each row to a row buffer.
// Latency: one cycle from acceptance of a row's last word to we=1.
// Backpressure: in_rdy is registered, high only while filling; low during the row write cycle.
module img_row_packer
  import img_pkg::*;
#(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int ROW_W    = DEF_ROW_W,
  parameter int NUM_ROWS = DEF_NUM_ROWS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_vld,
  input  logic [WORD_W-1:0]     in_data,
  output logic                  in_rdy,
  output logic                  we,
  output logic [ROW_ADDR_W-1:0] waddr,
  output logic [ROW_W-1:0]      wdata,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int WORDS  = ROW_W / WORD_W;
  localparam int WCNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WCNT_W-1:0]     LAST_WORD = WCNT_W'(WORDS - 1);
  localparam logic [ROW_ADDR_W-1:0] LAST_ROW  = ROW_ADDR_W'(NUM_ROWS - 1);

  state_t                  state;
  logic [WCNT_W-1:0]       word_cnt;
  logic [ROW_ADDR_W-1:0]   row_cnt;
  logic [ROW_W-1:0]        row_buf;
  logic [ROW_W-1:0]        row_next;
  logic                    accept;

  // in_rdy is a register, so acceptance never loops back through in_vld.
  assign accept = in_vld && in_rdy;

  // Row assembly with the incoming word dropped into its slot; used both to
  // update the assembly register and to hand the complete row to wdata.
  always_comb begin
    row_next = row_buf;
    row_next[int'(word_cnt) * WORD_W +: WORD_W] = in_data;
  end

  // Frame FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      word_cnt   <= '0;
      row_cnt    <= '0;
      row_buf    <= '0;
      in_rdy     <= 1'b0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // start beats a simultaneous abort because abort is ignored here.
          if (start) begin
            state    <= FILL;
            word_cnt <= '0;
            row_cnt  <= '0;
            in_rdy   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FILL: begin
          if (abort) begin
            // Drops the partial row, including a last word arriving this cycle.
            state    <= IDLE;
            word_cnt <= '0;
            row_cnt  <= '0;
            in_rdy   <= 1'b0;
            busy     <= 1'b0;
          end else if (accept) begin
            row_buf <= row_next;
            if (word_cnt == LAST_WORD) begin
              state    <= WRITE;
              word_cnt <= '0;
              in_rdy   <= 1'b0;
              we       <= 1'b1;
              waddr    <= row_cnt;
              wdata    <= row_next;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state    <= IDLE;
            word_cnt <= '0;
            row_cnt  <= '0;
            busy     <= 1'b0;
          end else if (row_cnt == LAST_ROW) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else begin
            state   <= FILL;
            row_cnt <= row_cnt + 1'b1;
            in_rdy  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          in_rdy <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
